// File: rtl/write_buffer_nline.sv
// Multi-entry line write buffer between the cache store path and the AXI
// write channel. Entries form a FIFO: writes merge into a matching unlocked
// entry or allocate at the tail, reads forward the youngest matching line,
// and the oldest entry drains through a valid/ready handshake.
module write_buffer_nline #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wreq_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [LINE_W-1:0]        wdata_i,
  input  logic [LINE_W/32-1:0]     wsel_i,
  output logic                     wack_o,
  output logic                     whit_o,
  input  logic                     rreq_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic                     rhit_o,
  output logic [LINE_W-1:0]        rdata_o,
  input  logic                     drain_en_i,
  output logic                     axi_wvalid_o,
  input  logic                     axi_wready_i,
  output logic [ADDR_W-1:0]        axi_waddr_o,
  output logic [LINE_W-1:0]        axi_wdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int WSEL_W = LINE_W / 32;
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int TAG_W  = ADDR_W - OFF;

  typedef enum logic {IDLE, SEND} state_t;

  // Word-granular merge of new data into an existing line.
  function automatic logic [LINE_W-1:0] merge_words(
    input logic [LINE_W-1:0] old_line,
    input logic [LINE_W-1:0] new_line,
    input logic [LINE_W-1:0] mask
  );
    return (old_line & ~mask) | (new_line & mask);
  endfunction

  logic [DEPTH-1:0]  vld;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] line_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  state_t            state;
  state_t            state_nxt;

  logic [TAG_W-1:0]  wtag;
  logic [TAG_W-1:0]  rtag;
  logic              wmatch;
  logic [PTR_W-1:0]  widx;
  logic              rmatch;
  logic [PTR_W-1:0]  ridx;
  logic [LINE_W-1:0] mask;
  logic              locked;
  logic              push;
  logic              merge;
  logic              pop;

  assign wtag   = waddr_i[ADDR_W-1:OFF];
  assign rtag   = raddr_i[ADDR_W-1:OFF];
  assign locked = (state == SEND);

  // Write match: at most one valid entry other than the locked head can match.
  always_comb begin
    wmatch = 1'b0;
    widx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (tag_q[i] == wtag) && !(locked && (PTR_W'(i) == head))) begin
        wmatch = 1'b1;
        widx   = PTR_W'(i);
      end
    end
  end

  // Read match: scan oldest to youngest so the youngest match wins.
  always_comb begin
    rmatch = 1'b0;
    ridx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[head + PTR_W'(k)] && (tag_q[head + PTR_W'(k)] == rtag)) begin
        rmatch = 1'b1;
        ridx   = head + PTR_W'(k);
      end
    end
  end

  // Expand 32-bit word enables into a bit mask.
  always_comb begin
    mask = '0;
    for (int w = 0; w < WSEL_W; w++) begin
      mask[w*32 +: 32] = {32{wsel_i[w]}};
    end
  end

  assign full_o       = (count == CNT_W'(DEPTH));
  assign empty_o      = (count == '0);
  assign count_o      = count;
  assign whit_o       = wreq_i & wmatch;
  assign wack_o       = wreq_i & (wmatch | ~full_o);
  assign push         = wack_o & ~wmatch;
  assign merge        = wack_o & wmatch;
  assign pop          = locked & axi_wready_i;
  assign count_nxt    = count + CNT_W'(push) - CNT_W'(pop);
  assign rhit_o       = rreq_i & rmatch;
  assign rdata_o      = rhit_o ? line_q[ridx] : '0;
  assign axi_wvalid_o = locked;
  assign axi_waddr_o  = {tag_q[head], {OFF{1'b0}}};
  assign axi_wdata_o  = line_q[head];

  // Control state: valid bits, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Entry payload: allocate at tail or merge into the matching entry.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= wtag;
      line_q[tail] <= wdata_i;
    end else if (merge) begin
      line_q[widx] <= merge_words(line_q[widx], wdata_i, mask);
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Drain FSM next state: back-to-back beats while entries remain and draining is allowed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if ((count != '0) && drain_en_i) state_nxt = SEND;
      SEND: if (axi_wready_i) state_nxt = ((count_nxt != '0) && drain_en_i) ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_write_buffer_nline.sv
// Bench for write_buffer_nline: a queue-based model of the buffer is checked
// against the DUT every cycle, plus directed literal checks from the test plan.
module tb_write_buffer_nline;

  localparam int DEPTH  = 4;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 32;
  localparam int OFF    = 4;
  localparam int TAG_W  = ADDR_W - OFF;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wreq_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [LINE_W-1:0] wdata_i;
  logic [3:0]        wsel_i;
  logic              wack_o;
  logic              whit_o;
  logic              rreq_i;
  logic [ADDR_W-1:0] raddr_i;
  logic              rhit_o;
  logic [LINE_W-1:0] rdata_o;
  logic              drain_en_i;
  logic              axi_wvalid_o;
  logic              axi_wready_i;
  logic [ADDR_W-1:0] axi_waddr_o;
  logic [LINE_W-1:0] axi_wdata_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;

  write_buffer_nline #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wreq_i(wreq_i), .waddr_i(waddr_i), .wdata_i(wdata_i), .wsel_i(wsel_i),
    .wack_o(wack_o), .whit_o(whit_o),
    .rreq_i(rreq_i), .raddr_i(raddr_i), .rhit_o(rhit_o), .rdata_o(rdata_o),
    .drain_en_i(drain_en_i), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_waddr_o(axi_waddr_o), .axi_wdata_o(axi_wdata_o),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: oldest entry at index 0; busy means a beat is on AXI.
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } ent_t;

  ent_t q[$];
  bit   busy;
  bit   chk_en = 0;

  function automatic int find_wr(input logic [TAG_W-1:0] t);
    int r = -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == t && !(busy && i == 0)) r = i;
    return r;
  endfunction

  function automatic int find_rd(input logic [TAG_W-1:0] t);
    int r = -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == t) r = i;
    return r;
  endfunction

  int m_wi, m_pre;
  bit m_wk, m_pop;

  // Model update on each rising edge from the pre-edge inputs.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      busy = 0;
    end else begin
      m_pre = q.size();
      m_wi  = wreq_i ? find_wr(waddr_i[ADDR_W-1:OFF]) : -1;
      m_wk  = wreq_i && (m_wi >= 0 || m_pre < DEPTH);
      m_pop = busy && axi_wready_i;
      if (m_wk) begin
        if (m_wi >= 0) begin
          for (int w = 0; w < 4; w++)
            if (wsel_i[w]) q[m_wi].data[w*32 +: 32] = wdata_i[w*32 +: 32];
        end else begin
          q.push_back('{tag: waddr_i[ADDR_W-1:OFF], data: wdata_i});
        end
      end
      if (m_pop) void'(q.pop_front());
      if (!busy)     busy = (m_pre != 0) && drain_en_i;
      else if (m_pop) busy = (q.size() != 0) && drain_en_i;
    end
  end

  int e_wi, e_ri;
  bit e_whit, e_wack, e_rhit;
  logic [LINE_W-1:0] e_rdata;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_wi    = find_wr(waddr_i[ADDR_W-1:OFF]);
      e_ri    = find_rd(raddr_i[ADDR_W-1:OFF]);
      e_whit  = wreq_i && (e_wi >= 0);
      e_wack  = wreq_i && (e_whit || q.size() < DEPTH);
      e_rhit  = rreq_i && (e_ri >= 0);
      e_rdata = e_rhit ? q[e_ri].data : '0;
      chk("m_whit",   LINE_W'(whit_o),       LINE_W'(e_whit));
      chk("m_wack",   LINE_W'(wack_o),       LINE_W'(e_wack));
      chk("m_rhit",   LINE_W'(rhit_o),       LINE_W'(e_rhit));
      chk("m_rdata",  rdata_o,               e_rdata);
      chk("m_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(busy));
      chk("m_count",  LINE_W'(count_o),      LINE_W'(q.size()));
      chk("m_full",   LINE_W'(full_o),       LINE_W'(q.size() == DEPTH));
      chk("m_empty",  LINE_W'(empty_o),      LINE_W'(q.size() == 0));
      if (busy) begin
        chk("m_waddr", LINE_W'(axi_waddr_o), LINE_W'({q[0].tag, 4'h0}));
        chk("m_wdata", axi_wdata_o,          q[0].data);
      end
    end
  end

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] a);
    return {a ^ 32'hD000_0000, a ^ 32'hC000_0000, a ^ 32'hB000_0000, a ^ 32'hA000_0000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [LINE_W-1:0] d, input logic [3:0] s);
    wreq_i  = 1'b1;
    waddr_i = a;
    wdata_i = d;
    wsel_i  = s;
  endtask

  logic [LINE_W-1:0] exp_line;

  initial begin
    rst = 1'b1; wreq_i = 0; waddr_i = '0; wdata_i = '0; wsel_i = '0;
    rreq_i = 0; raddr_i = '0; drain_en_i = 0; axi_wready_i = 0;
    @(posedge clk); #1;
    chk_en = 1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count",  LINE_W'(count_o),      LINE_W'(0));
    chk("rst_empty",  LINE_W'(empty_o),      LINE_W'(1));
    chk("rst_full",   LINE_W'(full_o),       LINE_W'(0));
    chk("rst_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(0));

    // Fill with draining disabled.
    for (int i = 1; i <= 4; i++) begin
      tick;
      wr(32'(i * 32'h100), pat(32'(i * 32'h100)), 4'hF);
      @(negedge clk);
      chk("fill_wack", LINE_W'(wack_o), LINE_W'(1));
    end
    tick;
    wreq_i = 0;
    @(negedge clk);
    chk("fill_count", LINE_W'(count_o), LINE_W'(4));
    chk("fill_full",  LINE_W'(full_o),  LINE_W'(1));
    tick;
    wr(32'h500, pat(32'h500), 4'hF);
    @(negedge clk);
    chk("full_wack", LINE_W'(wack_o), LINE_W'(0));
    tick;
    wr(32'h204, {LINE_W{1'b1}}, 4'b0010);
    @(negedge clk);
    chk("merge_wack", LINE_W'(wack_o), LINE_W'(1));
    chk("merge_whit", LINE_W'(whit_o), LINE_W'(1));
    tick;
    wreq_i = 0; rreq_i = 1; raddr_i = 32'h200;
    exp_line = pat(32'h200);
    exp_line[63:32] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("merge_count", LINE_W'(count_o), LINE_W'(4));
    chk("merge_data",  rdata_o,          exp_line);

    // Forwarding.
    tick;
    raddr_i = 32'h30C;
    @(negedge clk);
    chk("fwd_hit",  LINE_W'(rhit_o), LINE_W'(1));
    chk("fwd_data", rdata_o,         pat(32'h300));
    tick;
    raddr_i = 32'h600;
    @(negedge clk);
    chk("fwd_miss_hit",  LINE_W'(rhit_o), LINE_W'(0));
    chk("fwd_miss_data", rdata_o,         LINE_W'(0));

    // Back-to-back drain of four entries.
    tick;
    rreq_i = 0; drain_en_i = 1; axi_wready_i = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b2b_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(1));
      chk("b2b_waddr",  LINE_W'(axi_waddr_o),  LINE_W'(32'(k + 1) * 32'h100));
      tick;
    end
    @(negedge clk);
    chk("b2b_idle",  LINE_W'(axi_wvalid_o), LINE_W'(0));
    chk("b2b_empty", LINE_W'(empty_o),      LINE_W'(1));

    // Locked head: a write to the draining address allocates a new entry.
    tick;
    drain_en_i = 0; axi_wready_i = 0;
    wr(32'h100, pat(32'hA), 4'hF);
    tick;
    wreq_i = 0; drain_en_i = 1;
    tick; tick; tick;
    wr(32'h100, pat(32'hB), 4'hF);
    @(negedge clk);
    chk("lock_whit", LINE_W'(whit_o), LINE_W'(0));
    chk("lock_wack", LINE_W'(wack_o), LINE_W'(1));
    tick;
    wreq_i = 0; rreq_i = 1; raddr_i = 32'h100; drain_en_i = 0;
    @(negedge clk);
    chk("lock_count",  LINE_W'(count_o),      LINE_W'(2));
    chk("lock_wdata",  axi_wdata_o,           pat(32'hA));
    chk("lock_rdata",  rdata_o,               pat(32'hB));
    chk("lock_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(1));
    tick;
    rreq_i = 0; axi_wready_i = 1;
    tick;
    @(negedge clk);
    chk("lock_stop_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(0));
    chk("lock_stop_count",  LINE_W'(count_o),      LINE_W'(1));
    drain_en_i = 1;
    tick; tick; tick;
    @(negedge clk);
    chk("lock_empty", LINE_W'(empty_o), LINE_W'(1));

    // Wrap: writes interleaved with continuous draining.
    for (int i = 0; i < 8; i++) begin
      wr(32'h1000 + 32'(i) * 32'h40, pat(32'h1000 + 32'(i)), 4'hF);
      axi_wready_i = (i % 3) != 2;
      tick;
    end
    wreq_i = 0; axi_wready_i = 1;
    for (int i = 0; i < 12; i++) tick;
    @(negedge clk);
    chk("wrap_empty", LINE_W'(empty_o), LINE_W'(1));

    // Same-cycle pop and miss at count 2.
    tick;
    drain_en_i = 0; axi_wready_i = 0;
    wr(32'h2000, pat(32'h2000), 4'hF);
    tick;
    wr(32'h2040, pat(32'h2040), 4'hF);
    tick;
    wreq_i = 0; drain_en_i = 1;
    tick;
    wr(32'h2080, pat(32'h2080), 4'hF);
    axi_wready_i = 1;
    @(negedge clk);
    chk("pp_wack",  LINE_W'(wack_o),  LINE_W'(1));
    chk("pp_count0", LINE_W'(count_o), LINE_W'(2));
    tick;
    wreq_i = 0; axi_wready_i = 0;
    @(negedge clk);
    chk("pp_count", LINE_W'(count_o),     LINE_W'(2));
    chk("pp_waddr", LINE_W'(axi_waddr_o), LINE_W'(32'h2040));

    // Reset while a beat is presented.
    chk("rs_pre_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(1));
    tick;
    rst = 1;
    tick;
    rst = 0; rreq_i = 1; raddr_i = 32'h2040;
    @(negedge clk);
    chk("rs_wvalid", LINE_W'(axi_wvalid_o), LINE_W'(0));
    chk("rs_count",  LINE_W'(count_o),      LINE_W'(0));
    chk("rs_rhit",   LINE_W'(rhit_o),       LINE_W'(0));
    tick;
    raddr_i = 32'h2080;
    @(negedge clk);
    chk("rs_rhit2", LINE_W'(rhit_o), LINE_W'(0));
    tick;
    rreq_i = 0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/write_buffer_nline.md
Name: write_buffer_nline

Overview:
- Parametrised multi-entry write buffer between the data cache / uncached store path and the AXI write channel.
- Holds up to DEPTH line-aligned dirty lines in FIFO order.
- Merges partial writes into a matching entry and forwards the youngest matching data to reads.
- Drains the oldest entry through a valid/ready handshake that keeps address and data stable while valid is high.

Parameters:
DEPTH, 4, number of line entries; power of two, >=2
LINE_W, 128, line width in bits; multiple of 32
ADDR_W, 32, address width
(derived: WSEL_W=LINE_W/32; OFF=log2(LINE_W/8); CNT_W=log2(DEPTH)+1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
wreq_i  in  1  write request
waddr_i  in  ADDR_W  write address (low OFF bits ignored)
wdata_i  in  LINE_W  write data
wsel_i  in  WSEL_W  32-bit word enables, used on merge
wack_o  out  1  write accepted this cycle
whit_o  out  1  write address matches a mergeable entry
rreq_i  in  1  read probe
raddr_i  in  ADDR_W  read address
rhit_o  out  1  read address matches any valid entry
rdata_o  out  LINE_W  forwarded line, 0 when no hit or rreq_i=0
drain_en_i  in  1  permits starting a new drain (low while an uncached access owns AXI)
axi_wvalid_o  out  1  head entry presented to AXI
axi_wready_i  in  1  AXI accepts head entry
axi_waddr_o  out  ADDR_W  head address, low OFF bits zero
axi_wdata_o  out  LINE_W  head data
count_o  out  CNT_W  valid entries
full_o  out  1  count_o==DEPTH
empty_o  out  1  count_o==0

Behaviour:
- Reset: all valid bits 0; head=tail=0; count_o=0; FSM=IDLE.
- Reset outputs: axi_wvalid_o=0, full_o=0, empty_o=1. wack_o, whit_o and rhit_o are 0 unless a request arrives in the same cycle.
- Reset mid-drain drops axi_wvalid_o on the next cycle and discards all entries.
- Address compare uses only bits [ADDR_W-1:OFF].
- Head is "locked" while FSM=SEND.
- whit_o is combinational: wreq_i and the aligned address equals a valid, unlocked entry. At most one such entry exists (invariant).
- wack_o = wreq_i & (whit_o | ~full_o). This holds even if a pop occurs in the same cycle, so a full buffer never push-pops.
- Accepted hit: the entry is updated per word, new = (old & ~mask) | (wdata_i & mask), where mask expands wsel_i to 32-bit lanes. Count is unchanged.
- Accepted miss: wdata_i (wsel_i ignored) and the aligned address are written at tail. tail=(tail+1) mod DEPTH; count+1.
- A write matching only the locked head is a miss and allocates a new, younger entry.
- Reads: rhit_o and rdata_o are combinational and use pre-edge state. A same-cycle write or pop has no effect on them.
- Read match may include the locked head. With multiple matches, the youngest (closest to tail) wins.
- Drain FSM, IDLE: if count_o!=0 and drain_en_i, go to SEND on the next edge.
- Drain FSM, SEND: axi_wvalid_o=1, head address/data held stable. On axi_wready_i: pop head (valid=0, head=(head+1) mod DEPTH, count-1).
  - After the pop, stay in SEND if the post-pop count!=0 and drain_en_i; else go to IDLE.
  - Back-to-back drains therefore have no bubble.
- drain_en_i falling during SEND does not drop axi_wvalid_o; the current beat completes.
- Simultaneous pop and accepted miss (count<DEPTH): count unchanged; both pointers advance.
- Simultaneous pop and hit merge into a non-head entry: both take effect.
- Count arithmetic never wraps. Pointer wrap is modulo DEPTH.

Test Plan:
- Write-only fill: drain_en_i=0; writes 0x100,0x200,0x300,0x400 -> wack_o=1 each, count_o=4, full_o=1. Write 0x500 -> wack_o=0, count stays 4. Write 0x204 wsel=0010 -> wack_o=1, whit_o=1, only word1 of entry 0x200 changes.
- Forwarding: entry 0x300 data D; rreq_i=1, raddr_i=0x30C -> rhit_o=1, rdata_o=D. raddr_i=0x600 -> rhit_o=0, rdata_o=0.
- Locked head: one entry 0x100=A; drain_en_i=1, axi_wready_i=0 for 3 cycles. Write 0x100 wsel=1111 data B -> whit_o=0, new entry, count=2. axi_wdata_o stays A. Read 0x100 -> B.
- Back-to-back drain: 4 entries, drain_en_i=1, axi_wready_i=1 -> axi_wvalid_o high 4 consecutive cycles, addresses in FIFO order, then empty_o=1, FSM IDLE.
- Wrap and concurrency: 8 writes interleaved with drains -> pointers wrap past 3, order preserved. Same-cycle pop plus miss at count=2 -> count stays 2.
- Reset mid-SEND: rst=1 for one cycle while axi_wvalid_o=1 -> next cycle axi_wvalid_o=0, count_o=0, rhit_o=0 for all prior addresses.
